// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains the read port of a sync FIFO that has registered read data and
//   presents the words as a valid/ready stream framed into fixed-length bursts.
//   Because fifo_dout lags fifo_re by one cycle, the block tracks the read in
//   flight and lands returned words in a 3-entry skid queue. Reads are issued
//   from registered state only, so m_ready never reaches fifo_re
//   combinationally, and the stream still runs at one word per cycle.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   en          drain enable; low blocks new FIFO reads
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid the cycle after fifo_re
//   fifo_re     FIFO read enable (combinational)
//   m_valid     stream valid
//   m_ready     stream ready from the consumer
//   m_data      stream data (head of the skid queue)
//   m_last      final word of the current burst, qualified by m_valid
//   beat_cnt    position of the head word within its burst, 0..burst-1
module fifo_stream_reader #(
   parameter int dwith = 8,
   parameter int burst = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       fifo_empty,
   input  logic [dwith-1:0]           fifo_dout,
   output logic                       fifo_re,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [dwith-1:0]           m_data,
   output logic                       m_last,
   output logic [$clog2(burst):0]     beat_cnt
);

   localparam int              BW        = $clog2(burst) + 1;
   localparam logic [BW-1:0]   LAST_BEAT = BW'(burst - 1);

   logic [1:0]       occ;
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic             inflight;
   logic [dwith-1:0] skid_q [0:2];
   logic [2:0]       pending;
   logic             cap;
   logic             pop;

   // Queue pointers run over three slots, so they wrap at 2 rather than 3.
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Stage 0: read issue. Queued words plus the word still in flight must
   // leave a free slot, which is what lets a capture never be refused.
   assign pending = {1'b0, occ} + {2'b0, inflight};
   assign fifo_re = en & ~rst & ~fifo_empty & (pending < 3'd3);

   assign cap = inflight;
   assign pop = m_valid & m_ready;

   // Stage 1: in-flight tracking, queue bookkeeping and burst position.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= 1'b0;
         occ      <= 2'd0;
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         beat_cnt <= '0;
      end else begin
         inflight <= fifo_re;
         if (cap) wr_ptr <= ptr_inc(wr_ptr);
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({cap, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
         if (pop) beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
   end

   // Data storage is not reset; occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (cap) skid_q[wr_ptr] <= fifo_dout;
   end

   // Stage 2: stream outputs from the queue head. Data is forced to zero
   // while the queue is empty so stale storage never shows on the port.
   assign m_valid = (occ != 2'd0);
   assign m_data  = m_valid ? skid_q[rd_ptr] : '0;
   assign m_last  = m_valid & (beat_cnt == LAST_BEAT);

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       fifo_empty;
   logic [7:0] fifo_dout = 8'h00;
   logic       fifo_re;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       m_last;
   logic [2:0] beat_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   fifo_stream_reader #(.dwith(8), .burst(4)) dut (
      .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
      .fifo_dout(fifo_dout), .fifo_re(fifo_re), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   // Sync FIFO model with registered read data; its pointers ignore rst.
   logic [7:0] mem [0:63];
   int fwr = 0;
   int frd = 0;
   assign fifo_empty = (fwr == frd);
   always @(posedge clk) begin
      if (fifo_re) begin
         fifo_dout <= mem[frd[5:0]];
         frd       <= frd + 1;
      end
   end

   task automatic push(input logic [7:0] v);
      mem[fwr[5:0]] = v;
      fwr = fwr + 1;
   endtask

   // Observation log, gathered just before each active edge.
   logic [7:0] got_data [0:63];
   logic       got_last [0:63];
   logic [2:0] got_beat [0:63];
   int n_got, re_cnt, v_cnt, cyc, first_re, last_re, first_v, last_v;
   int stall_seen, stall_bad;
   logic       prev_stall;
   logic [7:0] prev_data;

   task automatic clear_log();
      n_got = 0; re_cnt = 0; v_cnt = 0; cyc = 0;
      first_re = -1; last_re = -1; first_v = -1; last_v = -1;
      stall_seen = 0; stall_bad = 0; prev_stall = 1'b0; prev_data = 8'h00;
   endtask

   task automatic tick();
      #1;
      if (fifo_re) begin
         re_cnt++;
         if (first_re < 0) first_re = cyc;
         last_re = cyc;
      end
      if (m_valid) begin
         v_cnt++;
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
      end
      if (prev_stall) begin
         stall_seen++;
         if (m_data !== prev_data) stall_bad++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
         got_data[n_got] = m_data;
         got_last[n_got] = m_last;
         got_beat[n_got] = beat_cnt;
         n_got++;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; m_ready = 1'b0;
      clear_log();
      tick(); tick();
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
      n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_data got=%h exp=00", m_data); end
      n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got=%b exp=0", m_last); end
      n_cmp++; if (beat_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_beat got=%0d exp=0", beat_cnt); end
      n_cmp++; if (fifo_re !== 1'b0) begin n_bad++; $display("FAIL reset_re got=%b exp=0", fifo_re); end
      rst = 1'b0;
   endtask

   task automatic test_burst();
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      en = 1'b1; m_ready = 1'b1;
      clear_log();
      repeat (14) tick();
      n_cmp++; if (re_cnt != 8) begin n_bad++; $display("FAIL burst_re_count got=%0d exp=8", re_cnt); end
      n_cmp++; if (last_re - first_re != 7) begin n_bad++; $display("FAIL burst_re_contig span=%0d exp=7", last_re - first_re); end
      n_cmp++; if (first_v - first_re != 2) begin n_bad++; $display("FAIL burst_latency got=%0d exp=2", first_v - first_re); end
      n_cmp++; if (last_v - first_v != 7) begin n_bad++; $display("FAIL burst_valid_contig span=%0d exp=7", last_v - first_v); end
      n_cmp++; if (n_got != 8) begin n_bad++; $display("FAIL burst_count got=%0d exp=8", n_got); end
      for (int i = 0; i < 8 && i < n_got; i++) begin
         n_cmp++; if (got_data[i] !== 8'h10 + 8'(i)) begin n_bad++; $display("FAIL burst_data[%0d] got=%h exp=%h", i, got_data[i], 8'h10 + 8'(i)); end
         n_cmp++; if (got_last[i] !== (i == 3 || i == 7)) begin n_bad++; $display("FAIL burst_last[%0d] got=%b exp=%b", i, got_last[i], (i == 3 || i == 7)); end
         n_cmp++; if (got_beat[i] !== 3'(i % 4)) begin n_bad++; $display("FAIL burst_beat[%0d] got=%0d exp=%0d", i, got_beat[i], i % 4); end
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
      en = 1'b1; m_ready = 1'b0;
      clear_log();
      repeat (6) tick();
      n_cmp++; if (re_cnt != 3) begin n_bad++; $display("FAIL bp_re_count got=%0d exp=3", re_cnt); end
      n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid got=%b exp=1", m_valid); end
      n_cmp++; if (m_data !== 8'h20) begin n_bad++; $display("FAIL bp_head got=%h exp=20", m_data); end
      n_cmp++; if (n_got != 0) begin n_bad++; $display("FAIL bp_no_accept got=%0d exp=0", n_got); end
      m_ready = 1'b1;
      clear_log();
      repeat (10) tick();
      n_cmp++; if (n_got != 6) begin n_bad++; $display("FAIL bp_count got=%0d exp=6", n_got); end
      n_cmp++; if (first_v != 0 || last_v != 5) begin n_bad++; $display("FAIL bp_gapless first=%0d last=%0d exp=0/5", first_v, last_v); end
      for (int i = 0; i < 6 && i < n_got; i++) begin
         n_cmp++; if (got_data[i] !== 8'h20 + 8'(i)) begin n_bad++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, got_data[i], 8'h20 + 8'(i)); end
      end
   endtask

   task automatic test_alternating();
      for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
      en = 1'b1;
      clear_log();
      for (int c = 0; c < 30; c++) begin
         m_ready = (c % 2 == 0);
         tick();
      end
      m_ready = 1'b1;
      n_cmp++; if (n_got != 10) begin n_bad++; $display("FAIL alt_count got=%0d exp=10", n_got); end
      for (int i = 0; i < 10 && i < n_got; i++) begin
         n_cmp++; if (got_data[i] !== 8'h30 + 8'(i)) begin n_bad++; $display("FAIL alt_data[%0d] got=%h exp=%h", i, got_data[i], 8'h30 + 8'(i)); end
      end
      n_cmp++; if (stall_seen == 0 || stall_bad != 0) begin n_bad++; $display("FAIL alt_stable stalls=%0d unstable=%0d exp=>0/0", stall_seen, stall_bad); end
   endtask

   task automatic test_en_gating();
      for (int i = 0; i < 5; i++) push(8'h40 + 8'(i));
      en = 1'b1; m_ready = 1'b1;
      clear_log();
      tick(); tick();
      en = 1'b0;
      re_cnt = 0;
      repeat (8) tick();
      n_cmp++; if (re_cnt != 0) begin n_bad++; $display("FAIL en_re_off got=%0d exp=0", re_cnt); end
      n_cmp++; if (n_got != 2) begin n_bad++; $display("FAIL en_partial got=%0d exp=2", n_got); end
      en = 1'b1;
      repeat (10) tick();
      n_cmp++; if (n_got != 5) begin n_bad++; $display("FAIL en_total got=%0d exp=5", n_got); end
      for (int i = 0; i < 5 && i < n_got; i++) begin
         n_cmp++; if (got_data[i] !== 8'h40 + 8'(i)) begin n_bad++; $display("FAIL en_data[%0d] got=%h exp=%h", i, got_data[i], 8'h40 + 8'(i)); end
         n_cmp++; if (got_last[i] !== (i == 3)) begin n_bad++; $display("FAIL en_last[%0d] got=%b exp=%b", i, got_last[i], (i == 3)); end
      end
   endtask

   task automatic test_empty_boundary();
      rst = 1'b1; en = 1'b0; m_ready = 1'b1;
      tick();
      rst = 1'b0;
      push(8'hAA);
      en = 1'b1;
      clear_log();
      n_cmp++; if (beat_cnt !== 3'd0) begin n_bad++; $display("FAIL empty_beat_before got=%0d exp=0", beat_cnt); end
      repeat (6) tick();
      n_cmp++; if (re_cnt != 1) begin n_bad++; $display("FAIL empty_re got=%0d exp=1", re_cnt); end
      n_cmp++; if (v_cnt != 1) begin n_bad++; $display("FAIL empty_valid_cycles got=%0d exp=1", v_cnt); end
      n_cmp++; if (n_got != 1 || got_data[0] !== 8'hAA) begin n_bad++; $display("FAIL empty_data n=%0d got=%h exp=1/aa", n_got, got_data[0]); end
      n_cmp++; if (beat_cnt !== 3'd1) begin n_bad++; $display("FAIL empty_beat_after got=%0d exp=1", beat_cnt); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
      en = 1'b1; m_ready = 1'b0;
      clear_log();
      repeat (3) tick();
      n_cmp++; if (re_cnt != 3 || m_valid !== 1'b1) begin n_bad++; $display("FAIL mid_prefill re=%0d valid=%b exp=3/1", re_cnt, m_valid); end
      rst = 1'b1;
      re_cnt = 0;
      tick();
      n_cmp++; if (re_cnt != 0) begin n_bad++; $display("FAIL mid_re_in_reset got=%0d exp=0", re_cnt); end
      n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got=%b exp=0", m_valid); end
      n_cmp++; if (beat_cnt !== 3'd0) begin n_bad++; $display("FAIL mid_beat got=%0d exp=0", beat_cnt); end
      n_cmp++; if (fifo_re !== 1'b0) begin n_bad++; $display("FAIL mid_re got=%b exp=0", fifo_re); end
      rst = 1'b0; m_ready = 1'b1;
      clear_log();
      repeat (8) tick();
      n_cmp++; if (n_got != 3) begin n_bad++; $display("FAIL mid_count got=%0d exp=3", n_got); end
      n_cmp++; if (got_data[0] !== 8'h53 || got_beat[0] !== 3'd0) begin n_bad++; $display("FAIL mid_first data=%h beat=%0d exp=53/0", got_data[0], got_beat[0]); end
   endtask

   initial begin
      test_reset();
      test_burst();
      test_backpressure();
      test_alternating();
      test_en_gating();
      test_empty_boundary();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
